// File: rtl/lut_eval_engine.sv
// Programmable N_IN-input Boolean evaluator with a double-buffered truth table.
// One-cycle latency; a single output register that stalls input only while a held result is not taken.
module lut_eval_engine #(
  parameter int          N_IN  = 5,
  parameter logic [255:0] INIT = 256'hC10C_EEA1,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic [3:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_f,
  output logic [3:0]       out_tag,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic             cfg_bit,
  input  logic             cfg_commit,
  input  logic             cfg_revert,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam int T = 1 << N_IN;
  localparam logic [T-1:0] INIT_T = INIT[T-1:0];

  logic [T-1:0] active_tbl;
  logic [T-1:0] shadow_tbl;
  logic [T-1:0] shadow_wr;
  logic         accept;
  logic         f_now;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign f_now    = active_tbl[in_vec];

  // Shadow image including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    shadow_wr = shadow_tbl;
    if (cfg_we) shadow_wr[cfg_addr] = cfg_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_tbl <= INIT_T;
      shadow_tbl <= INIT_T;
    end else if (cfg_commit) begin
      active_tbl <= shadow_wr;
      shadow_tbl <= shadow_wr;
    end else if (cfg_revert) begin
      shadow_tbl <= active_tbl;
    end else begin
      shadow_tbl <= shadow_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
      out_tag   <= 4'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_f     <= f_now;
      out_tag   <= in_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_cnt <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      if (eval_cnt != '1) eval_cnt <= eval_cnt + 1'b1;
      if (f_now && ones_cnt != '1) ones_cnt <= ones_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lut_eval_engine.sv
// Randomised scoreboard bench for lut_eval_engine, plus a narrow-counter instance for saturation.
module tb_lut_eval_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_vec;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_f;
  logic [3:0]  out_tag;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic        cfg_bit;
  logic        cfg_commit;
  logic        cfg_revert;
  logic [15:0] eval_cnt;
  logic [15:0] ones_cnt;

  logic        s_in_ready, s_out_valid, s_out_f;
  logic [3:0]  s_out_tag;
  logic [3:0]  s_eval_cnt, s_ones_cnt;

  always #5 clk = ~clk;

  lut_eval_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_tag(out_tag), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_bit(cfg_bit), .cfg_commit(cfg_commit), .cfg_revert(cfg_revert),
    .eval_cnt(eval_cnt), .ones_cnt(ones_cnt)
  );

  lut_eval_engine #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_vec(in_vec), .in_tag(in_tag), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_f(s_out_f), .out_tag(s_out_tag), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_bit(cfg_bit), .cfg_commit(cfg_commit), .cfg_revert(cfg_revert),
    .eval_cnt(s_eval_cnt), .ones_cnt(s_ones_cnt)
  );

  typedef struct {
    bit         f;
    logic [3:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state: plain arrays and integer counts.
  bit          m_active[32];
  bit          m_shadow[32];
  bit          m_ov;
  int          m_eval;
  int          m_ones;
  logic [31:0] init_v = 32'hC10C_EEA1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_active[i] = init_v[i];
      m_shadow[i] = init_v[i];
    end
    m_ov   = 1'b0;
    m_eval = 0;
    m_ones = 0;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_vec = 0; in_tag = 0; out_ready = 1;
    cfg_we = 0; cfg_addr = 0; cfg_bit = 0; cfg_commit = 0; cfg_revert = 0;
  endtask

  // One clock of stimulus; the model is advanced at the negedge before the edge that acts on it.
  task automatic step(input bit v, input logic [4:0] vec, input logic [3:0] tag, input bit ordy,
                      input bit we, input logic [4:0] a, input bit b, input bit cm, input bit rv);
    bit   acc;
    bit   f;
    bit   nxt[32];
    @(posedge clk);
    #1;
    in_valid = v; in_vec = vec; in_tag = tag; out_ready = ordy;
    cfg_we = we; cfg_addr = a; cfg_bit = b; cfg_commit = cm; cfg_revert = rv;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || ordy)});
    chk("eval_cnt", {16'd0, eval_cnt}, sat(m_eval, 65535));
    chk("ones_cnt", {16'd0, ones_cnt}, sat(m_ones, 65535));
    chk("sat_eval_cnt", {28'd0, s_eval_cnt}, sat(m_eval, 15));
    chk("sat_ones_cnt", {28'd0, s_ones_cnt}, sat(m_ones, 15));
    acc = v && (!m_ov || ordy);
    if (acc) begin
      f = m_active[vec];
      exp_q.push_back('{f: f, tag: tag});
      m_eval++;
      if (f) m_ones++;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    nxt = m_shadow;
    if (we) nxt[a] = b;
    if (cm) begin
      m_active = nxt;
      m_shadow = nxt;
    end else if (rv) begin
      m_shadow = m_active;
    end else begin
      m_shadow = nxt;
    end
  endtask

  task automatic eval1(input logic [4:0] vec, input logic [3:0] tag);
    step(1, vec, tag, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg1(input bit we, input logic [4:0] a, input bit b, input bit cm, input bit rv);
    step(0, 0, 0, 1, we, a, b, cm, rv);
  endtask

  task automatic check_reset_outputs(input string where);
    chk({where, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({where, "_out_f"}, {31'd0, out_f}, 0);
    chk({where, "_out_tag"}, {28'd0, out_tag}, 0);
    chk({where, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({where, "_eval_cnt"}, {16'd0, eval_cnt}, 0);
    chk({where, "_ones_cnt"}, {16'd0, ones_cnt}, 0);
    chk({where, "_sat_eval"}, {28'd0, s_eval_cnt}, 0);
  endtask

  // Monitor: compare whatever the DUT presents against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 0);
      end else begin
        chk("out_f", {31'd0, out_f}, {31'd0, exp_q[0].f});
        chk("out_tag", {28'd0, out_tag}, {28'd0, exp_q[0].tag});
        chk("sat_out_f", {31'd0, s_out_f}, {31'd0, exp_q[0].f});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // INIT sweep at full throughput.
    for (int i = 0; i < 32; i++) eval1(i[4:0], i[3:0]);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("sweep_eval_cnt", {16'd0, eval_cnt}, 32);
    chk("sweep_ones_cnt", {16'd0, ones_cnt}, 14);

    // Backpressure: hold the result while new requests wait.
    step(1, 5'd7, 4'd3, 1, 0, 0, 0, 0, 0);
    repeat (4) step(1, 5'd2, 4'd6, 0, 0, 0, 0, 0, 0);
    step(1, 5'd24, 4'd9, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Commit in the same cycle as an evaluation of the written entry.
    step(1, 5'd0, 4'd1, 1, 1, 5'd0, 0, 1, 0);
    eval1(5'd0, 4'd2);

    // Revert discards the shadow write; revert+commit lets the commit through.
    cfg1(1, 5'd5, 0, 0, 0);
    cfg1(0, 0, 0, 0, 1);
    cfg1(0, 0, 0, 1, 0);
    eval1(5'd5, 4'd4);
    cfg1(1, 5'd5, 0, 0, 0);
    cfg1(0, 0, 0, 1, 1);
    eval1(5'd5, 4'd5);
    // Revert together with a write: write is lost.
    cfg1(1, 5'd7, 0, 0, 1);
    cfg1(0, 0, 0, 1, 0);
    eval1(5'd7, 4'd8);

    // Randomised traffic with interleaved configuration.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom), 4'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 5'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end

    // Async reset while a result is held under backpressure.
    step(1, 5'd1, 4'd9, 0, 0, 0, 0, 0, 0);
    step(1, 5'd3, 4'd2, 0, 1, 5'd0, 0, 1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    m_reset();
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    eval1(5'd0, 4'd7);
    eval1(5'd28, 4'd1);

    repeat (4) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
